// File: rtl/dc_token_ring_fifo_dout_pipe_pkg.sv
// Shared token-ring helpers for the dual-clock FIFO halves: reset tokens,
// ring rotation and pair-position decode over a fixed maximum ring width.
package dc_fifo_pkg;

    localparam int TOK_MAX   = 64;
    localparam int TOK_IDX_W = 6;

    typedef logic [TOK_MAX-1:0] tok_t;

    localparam tok_t RD_TOKEN_RST = tok_t'('h3);
    localparam tok_t WR_TOKEN_RST = tok_t'('hc);

    // Rotate the low 'depth' bits of token left by n; bits above depth stay zero.
    function automatic tok_t rotl(input tok_t token, input int n, input int depth);
        tok_t r;
        r = '0;
        for (int i = 0; i < TOK_MAX; i++) begin
            if (i < depth) begin
                r[TOK_IDX_W'((i + n) % depth)] = token[TOK_IDX_W'(i)];
            end
        end
        return r;
    endfunction

    function automatic int tok_pos(input tok_t token, input int depth);
        int p;
        p = 0;
        for (int i = 0; i < TOK_MAX; i++) begin
            if ((i < depth) && token[TOK_IDX_W'(i)] && token[TOK_IDX_W'((i + 1) % depth)]) begin
                p = i;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/dc_token_ring_fifo_dout_pipe_if.sv
// Read-half bus: storage-side token/pointer exchange plus the consumer handshake.
interface dc_token_ring_fifo_dout_pipe_if #(
    parameter int DATA_WIDTH   = 10,
    parameter int BUFFER_DEPTH = 8
);
    localparam int LW = $clog2(BUFFER_DEPTH) + 1;

    logic [DATA_WIDTH-1:0]   data_async;
    logic [BUFFER_DEPTH-1:0] write_token;
    logic [BUFFER_DEPTH-1:0] read_pointer;
    logic [DATA_WIDTH-1:0]   data;
    logic                    valid;
    logic                    ready;
    logic [LW-1:0]           level;
    logic                    almost_empty;

    modport slave (
        input  data_async, write_token, ready,
        output read_pointer, data, valid, level, almost_empty
    );

    modport master (
        output data_async, write_token, ready,
        input  read_pointer, data, valid, level, almost_empty
    );
endinterface

// File: rtl/dc_token_ring_fifo_dout_pipe_ring.sv
// Two-hot token ring register; advance rotates the token one position left.
module dc_token_ring
    import dc_fifo_pkg::*;
#(
    parameter int               DEPTH       = 8,
    parameter logic [DEPTH-1:0] RESET_VALUE = DEPTH'(3)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    output logic [DEPTH-1:0] token
);

    logic [DEPTH-1:0] token_q;
    logic [DEPTH-1:0] token_d;
    tok_t             rot_ext;

    always_comb begin
        rot_ext = rotl(tok_t'(token_q), 1, DEPTH);
        token_d = token_q;
        if (advance) begin
            token_d = rot_ext[DEPTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            token_q <= RESET_VALUE;
        end else begin
            token_q <= token_d;
        end
    end

    assign token = token_q;

endmodule

// File: rtl/dc_token_ring_fifo_dout_pipe_sync.sv
// N-stage flop synchroniser for the incoming write token. Stage flops carry the
// cdc_sync_ prefix so CDC checks can identify them; nothing sits between stages.
module dc_synchronizer_n #(
    parameter int               WIDTH       = 8,
    parameter int               STAGES      = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] cdc_sync_q [STAGES];
    logic [WIDTH-1:0] cdc_sync_d [STAGES];

    always_comb begin
        cdc_sync_d[0] = din;
        for (int s = 1; s < STAGES; s++) begin
            cdc_sync_d[s] = cdc_sync_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < STAGES; s++) begin
            if (rst) begin
                cdc_sync_q[s] <= RESET_VALUE;
            end else begin
                cdc_sync_q[s] <= cdc_sync_d[s];
            end
        end
    end

    assign dout = cdc_sync_q[STAGES-1];

endmodule

// File: rtl/dc_token_ring_fifo_dout_pipe.sv
// Read-domain half of the token-ring dual-clock FIFO: write-token sync, read token,
// one-hot storage select, optional prefetch output register, level and almost-empty.
module dc_token_ring_fifo_dout_pipe
    import dc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 10,
    parameter int BUFFER_DEPTH = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int OUT_REG      = 1,
    parameter int AE_THRESH    = 1
) (
    input logic                         clk,
    input logic                         rst,
    dc_token_ring_fifo_dout_pipe_if.slave bus
);

    localparam int LW = $clog2(BUFFER_DEPTH) + 1;

    logic [BUFFER_DEPTH-1:0] read_token;
    logic [BUFFER_DEPTH-1:0] wsync;
    tok_t                    rt_ext;
    tok_t                    ws_ext;
    tok_t                    rot2_ext;
    tok_t                    rot3_ext;
    logic                    ring_empty;
    logic                    ring_valid;
    logic                    pop;
    logic [LW-1:0]           ring_level;
    logic [LW-1:0]           level_w;
    int                      pos_w;
    int                      pos_r;

    dc_synchronizer_n #(
        .WIDTH       (BUFFER_DEPTH),
        .STAGES      (SYNC_STAGES),
        .RESET_VALUE (BUFFER_DEPTH'(WR_TOKEN_RST))
    ) u_wsync (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.write_token),
        .dout (wsync)
    );

    dc_token_ring #(
        .DEPTH       (BUFFER_DEPTH),
        .RESET_VALUE (BUFFER_DEPTH'(RD_TOKEN_RST))
    ) u_rd_ring (
        .clk     (clk),
        .rst     (rst),
        .advance (pop),
        .token   (read_token)
    );

    // The ring is empty when the write pair sits exactly two slots ahead of the read pair.
    always_comb begin
        rt_ext     = tok_t'(read_token);
        ws_ext     = tok_t'(wsync);
        rot2_ext   = rotl(rt_ext, 2, BUFFER_DEPTH);
        rot3_ext   = rotl(rt_ext, 3, BUFFER_DEPTH);
        ring_empty = (ws_ext == rot2_ext);
        ring_valid = ~ring_empty;
        pos_w      = tok_pos(ws_ext, BUFFER_DEPTH);
        pos_r      = tok_pos(rt_ext, BUFFER_DEPTH);
        ring_level = LW'((pos_w - pos_r - 2 + 2 * BUFFER_DEPTH) % BUFFER_DEPTH);
    end

    assign bus.read_pointer = rot2_ext[BUFFER_DEPTH-1:0] & rot3_ext[BUFFER_DEPTH-1:0];

    if (OUT_REG != 0) begin : g_out_reg
        logic                  valid_q;
        logic                  valid_d;
        logic [DATA_WIDTH-1:0] data_q;
        logic [DATA_WIDTH-1:0] data_d;

        // Prefetch whenever the register is empty or being drained this cycle.
        always_comb begin
            pop     = ring_valid & (~valid_q | bus.ready);
            valid_d = valid_q;
            data_d  = data_q;
            if (pop) begin
                data_d  = bus.data_async;
                valid_d = 1'b1;
            end else if (bus.ready) begin
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end

        assign bus.valid = valid_q;
        assign bus.data  = data_q;
        assign level_w   = ring_level + LW'(valid_q);
    end else begin : g_out_comb
        always_comb begin
            pop = ring_valid & bus.ready;
        end

        assign bus.valid = ring_valid;
        assign bus.data  = bus.data_async;
        assign level_w   = ring_level;
    end

    assign bus.level        = level_w;
    assign bus.almost_empty = (int'(level_w) <= AE_THRESH);

endmodule

// File: tb/tb_dc_token_ring_fifo_dout_pipe.sv
// Directed bench for the read half: models the write-side storage and token, with
// a registered-output instance and a combinational-output instance side by side.
module tb_dc_token_ring_fifo_dout_pipe;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    logic [9:0] mem  [8];
    logic [9:0] mem0 [8];
    int         wr_pos;

    dc_token_ring_fifo_dout_pipe_if #(.DATA_WIDTH(10), .BUFFER_DEPTH(8)) bus ();
    dc_token_ring_fifo_dout_pipe_if #(.DATA_WIDTH(10), .BUFFER_DEPTH(8)) bus0 ();

    dc_token_ring_fifo_dout_pipe #(
        .DATA_WIDTH(10), .BUFFER_DEPTH(8), .SYNC_STAGES(2), .OUT_REG(1), .AE_THRESH(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    dc_token_ring_fifo_dout_pipe #(
        .DATA_WIDTH(10), .BUFFER_DEPTH(8), .SYNC_STAGES(2), .OUT_REG(0), .AE_THRESH(1)
    ) dut_comb (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int onehot_idx(input logic [7:0] v);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    function automatic logic [7:0] pair_tok(input int pos);
        logic [7:0] t;
        t = '0;
        t[pos % 8]       = 1'b1;
        t[(pos + 1) % 8] = 1'b1;
        return t;
    endfunction

    always_comb bus.data_async  = mem[onehot_idx(bus.read_pointer)];
    always_comb bus0.data_async = mem0[onehot_idx(bus0.read_pointer)];

    task automatic write_word(input logic [9:0] val);
        wr_pos          = (wr_pos + 1) % 8;
        mem[wr_pos]     = val;
        bus.write_token = pair_tok(wr_pos);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst              = 1'b1;
        bus.ready        = 1'b0;
        bus.write_token  = 8'h0c;
        bus0.ready       = 1'b0;
        bus0.write_token = 8'h0c;
        wr_pos           = 2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", bus.valid); end
        checks++; if (bus.level !== 4'd0) begin errors++; $display("[TB] FAIL reset_level: got %0d expected 0", bus.level); end
        checks++; if (bus.almost_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_ae: got %0b expected 1", bus.almost_empty); end
        checks++; if (bus.read_pointer !== 8'h08) begin errors++; $display("[TB] FAIL reset_rp: got %0h expected 08", bus.read_pointer); end
        rst = 1'b0;
    endtask

    task automatic test_single_word();
        bus.ready = 1'b1;
        write_word(10'h155);
        tick();
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL single_valid_e1: got %0b expected 0", bus.valid); end
        tick();
        checks++; if (bus.level !== 4'd1) begin errors++; $display("[TB] FAIL single_level_e2: got %0d expected 1", bus.level); end
        checks++; if (bus.read_pointer !== 8'h08) begin errors++; $display("[TB] FAIL single_rp_e2: got %0h expected 08", bus.read_pointer); end
        tick();
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid_e3: got %0b expected 1", bus.valid); end
        checks++; if (bus.data !== 10'h155) begin errors++; $display("[TB] FAIL single_data_e3: got %0h expected 155", bus.data); end
        tick();
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL single_valid_e4: got %0b expected 0", bus.valid); end
        checks++; if (bus.level !== 4'd0) begin errors++; $display("[TB] FAIL single_level_e4: got %0d expected 0", bus.level); end
        checks++; if (bus.read_pointer !== 8'h10) begin errors++; $display("[TB] FAIL single_rp_e4: got %0h expected 10", bus.read_pointer); end
        bus.ready = 1'b0;
    endtask

    task automatic test_hold_and_drain();
        logic [9:0] v;
        bus.ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            write_word(10'(10'h0a0 + 10'(k) * 10'h023));
            tick();
        end
        repeat (3) tick();
        checks++; if (bus.level !== 4'd5) begin errors++; $display("[TB] FAIL hold_level: got %0d expected 5", bus.level); end
        checks++; if (bus.almost_empty !== 1'b0) begin errors++; $display("[TB] FAIL hold_ae: got %0b expected 0", bus.almost_empty); end
        for (int c = 0; c < 3; c++) begin
            checks++; if (bus.valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_valid: got %0b expected 1", bus.valid); end
            checks++; if (bus.data !== 10'h0a0) begin errors++; $display("[TB] FAIL hold_data: got %0h expected 0a0", bus.data); end
            tick();
        end
        bus.ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            v = 10'(10'h0a0 + 10'(k) * 10'h023);
            checks++; if (bus.valid !== 1'b1) begin errors++; $display("[TB] FAIL drain_valid: got %0b expected 1", bus.valid); end
            checks++; if (bus.data !== v) begin errors++; $display("[TB] FAIL drain_data: got %0h expected %0h", bus.data, v); end
            checks++; if (bus.level !== 4'(5 - k)) begin errors++; $display("[TB] FAIL drain_level: got %0d expected %0d", bus.level, 5 - k); end
            checks++; if (bus.almost_empty !== ((5 - k) <= 1)) begin errors++; $display("[TB] FAIL drain_ae: got %0b expected %0b", bus.almost_empty, (5 - k) <= 1); end
            tick();
        end
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty_valid: got %0b expected 0", bus.valid); end
        checks++; if (bus.level !== 4'd0) begin errors++; $display("[TB] FAIL drain_empty_level: got %0d expected 0", bus.level); end
        bus.ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [9:0] expq [$];
        logic [9:0] v;
        logic [7:0] mask;
        logic [7:0] prev_rp;
        int         sent;
        int         got;
        int         moves;
        int         max_level;
        int         first_cyc;
        int         last_cyc;
        sent = 0; got = 0; moves = 0; max_level = 0; first_cyc = -1; last_cyc = -1;
        mask = '0;
        prev_rp = bus.read_pointer;
        bus.ready = 1'b1;
        for (int cyc = 0; cyc < 80 && got < 20; cyc++) begin
            if (bus.valid === 1'b1) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("[TB] FAIL stream_data: got %0h expected no word", bus.data);
                end else begin
                    if (bus.data !== expq[0]) begin errors++; $display("[TB] FAIL stream_data: got %0h expected %0h", bus.data, expq[0]); end
                    void'(expq.pop_front());
                end
                got++;
            end
            mask = mask | bus.read_pointer;
            if (bus.read_pointer !== prev_rp) moves++;
            prev_rp = bus.read_pointer;
            if (int'(bus.level) > max_level) max_level = int'(bus.level);
            if (sent < 20) begin
                v = 10'(10'h201 + 10'(sent) * 10'h02f);
                write_word(v);
                expq.push_back(v);
                sent++;
            end
            tick();
        end
        checks++; if (got != 20) begin errors++; $display("[TB] FAIL stream_count: got %0d expected 20", got); end
        checks++; if (mask !== 8'hff) begin errors++; $display("[TB] FAIL stream_rp_mask: got %0h expected ff", mask); end
        checks++; if (moves != 20) begin errors++; $display("[TB] FAIL stream_rp_moves: got %0d expected 20", moves); end
        checks++; if (last_cyc - first_cyc + 1 != 20) begin errors++; $display("[TB] FAIL stream_throughput: got %0d expected 20", last_cyc - first_cyc + 1); end
        checks++; if (max_level > 7) begin errors++; $display("[TB] FAIL stream_max_level: got %0d expected <=7", max_level); end
        bus.ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            write_word(10'(10'h3c0 + 10'(k)));
            tick();
        end
        repeat (4) tick();
        checks++; if (bus.level !== 4'd3) begin errors++; $display("[TB] FAIL midrst_pre_level: got %0d expected 3", bus.level); end
        rst             = 1'b1;
        bus.write_token = 8'h0c;
        wr_pos          = 2;
        tick();
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid: got %0b expected 0", bus.valid); end
        checks++; if (bus.level !== 4'd0) begin errors++; $display("[TB] FAIL midrst_level: got %0d expected 0", bus.level); end
        checks++; if (bus.read_pointer !== 8'h08) begin errors++; $display("[TB] FAIL midrst_rp: got %0h expected 08", bus.read_pointer); end
        checks++; if (bus.almost_empty !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ae: got %0b expected 1", bus.almost_empty); end
        rst = 1'b0;
        repeat (3) tick();
        checks++; if (bus.level !== 4'd0) begin errors++; $display("[TB] FAIL midrst_after_level: got %0d expected 0", bus.level); end
    endtask

    task automatic test_comb_output();
        bus0.ready       = 1'b0;
        mem0[3]          = 10'h2aa;
        bus0.write_token = 8'h18;
        tick();
        checks++; if (bus0.valid !== 1'b0) begin errors++; $display("[TB] FAIL comb_valid_e1: got %0b expected 0", bus0.valid); end
        tick();
        checks++; if (bus0.valid !== 1'b1) begin errors++; $display("[TB] FAIL comb_valid_e2: got %0b expected 1", bus0.valid); end
        checks++; if (bus0.data !== 10'h2aa) begin errors++; $display("[TB] FAIL comb_data_e2: got %0h expected 2aa", bus0.data); end
        checks++; if (bus0.level !== 4'd1) begin errors++; $display("[TB] FAIL comb_level_e2: got %0d expected 1", bus0.level); end
        mem0[3] = 10'h0f0;
        #1;
        checks++; if (bus0.data !== 10'h0f0) begin errors++; $display("[TB] FAIL comb_data_track: got %0h expected 0f0", bus0.data); end
        bus0.ready = 1'b1;
        tick();
        checks++; if (bus0.valid !== 1'b0) begin errors++; $display("[TB] FAIL comb_valid_pop: got %0b expected 0", bus0.valid); end
        checks++; if (bus0.read_pointer !== 8'h10) begin errors++; $display("[TB] FAIL comb_rp_pop: got %0h expected 10", bus0.read_pointer); end
        checks++; if (bus0.level !== 4'd0) begin errors++; $display("[TB] FAIL comb_level_pop: got %0d expected 0", bus0.level); end
        bus0.ready = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mem[i]  = '0;
            mem0[i] = '0;
        end
        @(negedge clk);
        test_reset();
        test_single_word();
        test_hold_and_drain();
        test_back_to_back();
        test_reset_mid();
        test_comb_output();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
